mult_div_sequencer: RTL and testbench



---
 rtl/md_pkg.sv | 21 ++
 rtl/md_step.sv | 53 +++++
 rtl/mult_div_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide path:
// sequencer states, op select and the funct codes the control unit decodes.
package md_pkg;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_RUN  = 3'd1,
        MD_FIN  = 3'd2,
        MD_DONE = 3'd3,
        MD_HOLD = 3'd4
    } md_state_t;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    localparam logic [5:0] MD_FN_MFHI = 6'h10;
    localparam logic [5:0] MD_FN_MFLO = 6'h12;
    localparam logic [5:0] MD_FN_MULT = 6'h18;
    localparam logic [5:0] MD_FN_DIV  = 6'h1A;

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: Booth multiply step or restoring divide step,
// chosen by op. Purely combinational.
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_op,
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_lo,
    input  logic             i_q1,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_q1
);

    logic [WIDTH:0] w_m;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;

    assign w_m    = {i_opnd[WIDTH-1], i_opnd};
    assign w_shl  = {i_acc[WIDTH-1:0], i_lo[WIDTH-1]};
    assign w_diff = w_shl - {1'b0, i_opnd};

    always_comb begin
        w_sum = i_acc;
        unique case ({i_lo[0], i_q1})
            2'b01:   w_sum = i_acc + w_m;
            2'b10:   w_sum = i_acc - w_m;
            default: w_sum = i_acc;
        endcase
    end

    always_comb begin
        o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};
        o_q1  = i_lo[0];
        if (i_op == MD_OP_DIV) begin
            o_q1 = 1'b0;
            // Restore by simply keeping the shifted value when the trial goes negative
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff;
                o_lo  = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shl;
                o_lo  = {i_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative signed mult/div for the HI/LO path: captures operands,
// runs WIDTH iterations, sign-corrects and pulses done.
module mult_div_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t        r_state;
    md_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic             r_sgn_a;
    logic             r_sgn_q;
    logic             r_dz;
    logic             r_q1;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi_o;
    logic [WIDTH-1:0] r_lo_o;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH:0]   w_step_acc;
    logic [WIDTH-1:0] w_step_lo;
    logic             w_step_q1;
    logic             w_last;
    logic             w_b_zero;

    assign w_abs_a  = a[WIDTH-1] ? -a : a;
    assign w_abs_b  = b[WIDTH-1] ? -b : b;
    assign w_quot   = r_sgn_q ? -r_lo : r_lo;
    assign w_rem    = r_sgn_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_b_zero = (b == '0);
    assign hi       = r_hi_o;
    assign lo       = r_lo_o;

    md_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_lo   (r_lo),
        .i_q1   (r_q1),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc),
        .o_lo   (w_step_lo),
        .o_q1   (w_step_q1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        unique case (r_state)
            MD_IDLE: begin
                if (start)
                    w_next = (op == MD_OP_DIV && w_b_zero) ? MD_DONE : MD_RUN;
            end
            MD_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = MD_FIN;
            end
            MD_FIN: begin
                busy   = 1'b1;
                w_next = MD_DONE;
            end
            MD_DONE: begin
                done     = 1'b1;
                div_zero = r_dz;
                w_next   = MD_HOLD;
            end
            MD_HOLD: begin
                // start is still high from the control unit's wait state
                if (!start) w_next = MD_IDLE;
            end
            default: w_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_op    <= MD_OP_MULT;
            r_sgn_a <= 1'b0;
            r_sgn_q <= 1'b0;
            r_dz    <= 1'b0;
            r_q1    <= 1'b0;
            r_acc   <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_hi_o  <= '0;
            r_lo_o  <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_q1  <= 1'b0;
                        if (op == MD_OP_DIV) begin
                            r_lo    <= w_abs_a;
                            r_opnd  <= w_abs_b;
                            r_sgn_a <= a[WIDTH-1];
                            r_sgn_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_dz    <= w_b_zero;
                        end else begin
                            r_lo    <= b;
                            r_opnd  <= a;
                            r_sgn_a <= 1'b0;
                            r_sgn_q <= 1'b0;
                            r_dz    <= 1'b0;
                        end
                    end
                end
                MD_RUN: begin
                    r_acc <= w_step_acc;
                    r_lo  <= w_step_lo;
                    r_q1  <= w_step_q1;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                MD_FIN: begin
                    if (r_op == MD_OP_DIV) begin
                        r_hi_o <= w_rem;
                        r_lo_o <= w_quot;
                    end else begin
                        r_hi_o <= r_acc[WIDTH-1:0];
                        r_lo_o <= r_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Randomized bench for mult_div_sequencer against an arithmetic
// reference model (signed 64-bit products and truncating division).
module tb_mult_div_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mult_div_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    function automatic void model(input logic mop, input logic [31:0] ma,
                                  input logic [31:0] mb,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output logic edz, output int elat);
        longint sa, sb, p, q, r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        edz  = 1'b0;
        elat = W + 2;
        if (mop == 1'b0) begin
            p = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (sb == 0) begin
            edz  = 1'b1;
            elat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            m_hi = r[31:0];
            m_lo = q[31:0];
        end
        ehi = m_hi;
        elo = m_lo;
    endfunction

    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          input bit scr, output int lat, output int busy_n,
                          output int dz_n, output logic [31:0] rhi,
                          output logic [31:0] rlo, output logic rdz,
                          output logic done_after);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        lat = -1; busy_n = 0; dz_n = 0;
        rhi = hi; rlo = lo; rdz = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_n++;
            if (div_zero) dz_n++;
            if (done) begin
                lat = k; rhi = hi; rlo = lo; rdz = div_zero;
                break;
            end
            if (scr) begin
                a = $urandom; b = $urandom; op = 1'($urandom);
            end
        end
        start = 1'b0;
        @(negedge clk);
        done_after = done;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #3;
        n_tests++;
        if ({busy, done, div_zero, hi, lo} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, div_zero, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_mult_basic();
        int lat, bn, dzn; logic [31:0] rh, rl, eh, el; logic rd, da, ed; int el_t;
        model(1'b0, 32'd7, 32'hFFFFFFFD, eh, el, ed, el_t);
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, lat, bn, dzn, rh, rl, rd, da);
        n_tests++;
        if (lat !== 34) begin n_fail++; $display("FAIL mult_latency: got %0d want 34", lat); end
        n_tests++;
        if (bn !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 33", bn); end
        n_tests++;
        if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFEB) begin
            n_fail++; $display("FAIL mult_7x-3: got %h_%h want ffffffff_ffffffeb", rh, rl);
        end
        n_tests++;
        if (da !== 1'b0 || dzn !== 0) begin
            n_fail++; $display("FAIL mult_done_pulse: got done_after=%b dz=%0d want 0 0", da, dzn);
        end
    endtask

    task automatic test_div_basic();
        int lat, bn, dzn; logic [31:0] rh, rl, eh, el; logic rd, da, ed; int el_t;
        model(1'b1, 32'hFFFFFFF9, 32'd2, eh, el, ed, el_t);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bn, dzn, rh, rl, rd, da);
        n_tests++;
        if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFFD || rd !== 1'b0 || lat !== 34) begin
            n_fail++;
            $display("FAIL div_-7/2: got hi=%h lo=%h dz=%b lat=%0d want ffffffff fffffffd 0 34",
                     rh, rl, rd, lat);
        end
    endtask

    task automatic test_div_zero();
        int lat, bn, dzn; logic [31:0] rh, rl, eh, el; logic rd, da, ed; int el_t;
        model(1'b1, 32'h451, 32'h20, eh, el, ed, el_t);
        run_op(1'b1, 32'h451, 32'h20, 1'b0, lat, bn, dzn, rh, rl, rd, da);
        n_tests++;
        if ({rh, rl} !== {32'h11, 32'h22}) begin
            n_fail++; $display("FAIL div_prior: got hi=%h lo=%h want 11 22", rh, rl);
        end
        model(1'b1, 32'd5, 32'd0, eh, el, ed, el_t);
        run_op(1'b1, 32'd5, 32'd0, 1'b0, lat, bn, dzn, rh, rl, rd, da);
        n_tests++;
        if (lat !== 1 || rd !== 1'b1 || dzn !== 1 || da !== 1'b0) begin
            n_fail++;
            $display("FAIL div_zero_pulse: got lat=%0d dz=%b dz_cnt=%0d done_after=%b want 1 1 1 0",
                     lat, rd, dzn, da);
        end
        n_tests++;
        if ({hi, lo} !== {32'h11, 32'h22}) begin
            n_fail++; $display("FAIL div_zero_keep: got hi=%h lo=%h want 11 22", hi, lo);
        end
    endtask

    task automatic test_boundaries();
        int lat, bn, dzn; logic [31:0] rh, rl, eh, el; logic rd, da, ed; int el_t;
        model(1'b0, 32'h80000000, 32'h80000000, eh, el, ed, el_t);
        run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, lat, bn, dzn, rh, rl, rd, da);
        n_tests++;
        if ({rh, rl} !== 64'h40000000_00000000) begin
            n_fail++; $display("FAIL mult_min_min: got %h_%h want 40000000_00000000", rh, rl);
        end
        model(1'b1, 32'h80000000, 32'hFFFFFFFF, eh, el, ed, el_t);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bn, dzn, rh, rl, rd, da);
        n_tests++;
        if (rl !== 32'h80000000 || rh !== 32'h0 || dzn !== 0) begin
            n_fail++;
            $display("FAIL div_overflow: got hi=%h lo=%h dz_cnt=%0d want 0 80000000 0", rh, rl, dzn);
        end
    endtask

    task automatic test_hold();
        int lat, bn, dzn, extra; logic [31:0] rh, rl, eh, el; logic rd, da, ed; int el_t;
        model(1'b0, 32'd3, 32'd5, eh, el, ed, el_t);
        @(negedge clk);
        op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin lat = k; break; end
        end
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_tests++;
        if (lat !== 34 || extra !== 0) begin
            n_fail++; $display("FAIL hold_retrigger: got lat=%0d extra_done=%0d want 34 0", lat, extra);
        end
        start = 1'b0;
        model(1'b0, 32'd9, 32'hFFFFFFFE, eh, el, ed, el_t);
        run_op(1'b0, 32'd9, 32'hFFFFFFFE, 1'b0, lat, bn, dzn, rh, rl, rd, da);
        n_tests++;
        if (lat !== 34 || {rh, rl} !== {eh, el}) begin
            n_fail++;
            $display("FAIL hold_restart: got lat=%0d %h_%h want 34 %h_%h", lat, rh, rl, eh, el);
        end
    endtask

    task automatic test_async_reset();
        int lat, bn, dzn, seen; logic [31:0] rh, rl, eh, el; logic rd, da, ed; int el_t;
        @(negedge clk);
        op = 1'b0; a = $urandom; b = $urandom; start = 1'b1;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        start = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, div_zero, hi, lo} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, div_zero, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset_discard: got %0d active cycles want 0", seen);
        end
        a = $urandom; b = $urandom;
        model(1'b0, a, b, eh, el, ed, el_t);
        run_op(1'b0, a, b, 1'b0, lat, bn, dzn, rh, rl, rd, da);
        n_tests++;
        if (lat !== 34 || {rh, rl} !== {eh, el}) begin
            n_fail++;
            $display("FAIL after_reset_op: got lat=%0d %h_%h want 34 %h_%h", lat, rh, rl, eh, el);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h80000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h0;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int lat, bn, dzn, el_t; logic [31:0] rh, rl, eh, el, x, y; logic rd, da, ed, o;
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom);
            x = pick();
            y = pick();
            model(o, x, y, eh, el, ed, el_t);
            run_op(o, x, y, 1'b1, lat, bn, dzn, rh, rl, rd, da);
            n_tests++;
            if (lat !== el_t) begin
                n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, el_t);
            end
            n_tests++;
            if (rh !== eh) begin
                n_fail++; $display("FAIL rand%0d_hi op=%b a=%h b=%h: got %h want %h", i, o, x, y, rh, eh);
            end
            n_tests++;
            if (rl !== el) begin
                n_fail++; $display("FAIL rand%0d_lo op=%b a=%h b=%h: got %h want %h", i, o, x, y, rl, el);
            end
            n_tests++;
            if (rd !== ed) begin
                n_fail++; $display("FAIL rand%0d_div_zero: got %b want %b", i, rd, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div_basic();
        test_div_zero();
        test_boundaries();
        test_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
